// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped instruction cache, one 32-bit word per line, byte-wise refill
//
// Ports:
//   clk_in          rising-edge clock
//   rst_in          asynchronous active-low reset
//   rdy_in          global ready; low freezes all state and masks mem_req_out
//   flush_in        abort current lookup/refill (mispredict)
//   if_req_in       fetch request from IF, held until instr_valid_out is seen
//   if_pc_in        fetch PC, bits [1:0] ignored
//   instr_valid_out one-cycle pulse qualifying instr_out
//   instr_out       fetched instruction word (little-endian)
//   mem_req_out     byte read request to the arbiter
//   mem_a_out       byte address of the current request
//   mem_gnt_in      arbiter accepted mem_a_out this cycle
//   mem_din_in      RAM byte, valid the cycle after a grant
module icache #(
    parameter int IDX_W = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        flush_in,
    input  logic        if_req_in,
    input  logic [31:0] if_pc_in,
    output logic        instr_valid_out,
    output logic [31:0] instr_out,
    output logic        mem_req_out,
    output logic [31:0] mem_a_out,
    input  logic        mem_gnt_in,
    input  logic [7:0]  mem_din_in
);
    localparam int LINES = 1 << IDX_W;
    localparam int TAG_W = 30 - IDX_W;

    typedef enum logic {IDLE, REFILL} state_t;

    state_t             state, state_nxt;
    logic [LINES-1:0]   line_valid;
    logic [TAG_W-1:0]   tag_mem [LINES];
    logic [31:0]        data_mem [LINES];
    logic [31:0]        miss_addr;
    logic [2:0]         issue_cnt;
    logic [1:0]         recv_cnt;
    logic               pending;
    logic [23:0]        byte_buf;

    logic [IDX_W-1:0]   req_idx, miss_idx;
    logic [TAG_W-1:0]   req_tag, miss_tag;
    logic               sample, hit, granted, fill_done;
    logic [31:0]        fill_word;

    // PC byte-offset bits carry no information for a word cache
    wire unused_pc_bits = &{1'b0, if_pc_in[1:0]};

    always_comb begin
        req_idx   = if_pc_in[IDX_W+1:2];
        req_tag   = if_pc_in[31:IDX_W+2];
        miss_idx  = miss_addr[IDX_W+1:2];
        miss_tag  = miss_addr[31:IDX_W+2];
        // a request is only looked at once its previous answer has been consumed
        sample    = if_req_in && !instr_valid_out && !flush_in;
        hit       = line_valid[req_idx] && (tag_mem[req_idx] == req_tag);
        mem_req_out = rdy_in && (state == REFILL) && !issue_cnt[2];
        mem_a_out   = (state == REFILL) ? miss_addr + {29'b0, issue_cnt} : 32'b0;
        granted   = mem_req_out && mem_gnt_in;
        fill_done = (state == REFILL) && pending && (recv_cnt == 2'd3);
        // byte_buf holds bytes 2..0, the arriving byte is the most significant
        fill_word = {mem_din_in, byte_buf};

        state_nxt = state;
        if (flush_in) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (sample && !hit) state_nxt = REFILL;
                REFILL:  if (fill_done)      state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state           <= IDLE;
            line_valid      <= '0;
            instr_valid_out <= 1'b0;
            instr_out       <= 32'b0;
            miss_addr       <= 32'b0;
            issue_cnt       <= 3'd0;
            recv_cnt        <= 2'd0;
            pending         <= 1'b0;
            byte_buf        <= 24'b0;
        end else if (rdy_in) begin
            state           <= state_nxt;
            instr_valid_out <= 1'b0;
            if (flush_in) begin
                // any byte still in flight from a grant this cycle is dropped
                pending <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (sample) begin
                            if (hit) begin
                                instr_out       <= data_mem[req_idx];
                                instr_valid_out <= 1'b1;
                            end else begin
                                miss_addr <= {if_pc_in[31:2], 2'b00};
                                issue_cnt <= 3'd0;
                                recv_cnt  <= 2'd0;
                                pending   <= 1'b0;
                            end
                        end
                    end
                    REFILL: begin
                        pending <= granted;
                        if (granted) issue_cnt <= issue_cnt + 3'd1;
                        if (pending) begin
                            recv_cnt <= recv_cnt + 2'd1;
                            byte_buf <= {mem_din_in, byte_buf[23:8]};
                            if (recv_cnt == 2'd3) begin
                                line_valid[miss_idx] <= 1'b1;
                                instr_out            <= fill_word;
                                instr_valid_out      <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // payload arrays need no reset: line_valid gates every read
    always_ff @(posedge clk_in) begin
        if (rdy_in && !flush_in && fill_done) begin
            tag_mem[miss_idx]  <= miss_tag;
            data_mem[miss_idx] <= fill_word;
        end
    end
endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - directed self-checking bench for icache with a behavioural cache/RAM model
module tb_icache;
    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, flush_in, if_req_in, mem_gnt_in;
    logic [31:0] if_pc_in;
    logic        instr_valid_out, mem_req_out;
    logic [31:0] instr_out, mem_a_out;
    logic [7:0]  mem_din_in;

    icache #(.IDX_W(8)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .if_req_in(if_req_in), .if_pc_in(if_pc_in),
        .instr_valid_out(instr_valid_out), .instr_out(instr_out),
        .mem_req_out(mem_req_out), .mem_a_out(mem_a_out),
        .mem_gnt_in(mem_gnt_in), .mem_din_in(mem_din_in)
    );

    always #5 clk_in = ~clk_in;

    int vectors = 0;
    int miscompares = 0;

    // behavioural model: backing RAM and a direct-mapped tag/valid table
    logic [7:0]  ram [4096];
    bit          m_valid [256];
    logic [21:0] m_tag [256];

    // bookkeeping shared between the driver and the compare process
    logic [31:0] exp_base = 0, exp_word = 0, last_word = 0, gnt_addr = 0;
    int          grants = 0, req_cycles = 0, pulses = 0, gnt_block = 0;
    bit          prev_valid = 0, gnt_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ram_word(input logic [31:0] a);
        logic [11:0] b;
        b = a[11:0];
        return {ram[b + 12'd3], ram[b + 12'd2], ram[b + 12'd1], ram[b]};
    endfunction

    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 256; i++) m_valid[i] = 0;
    endtask

    // compare process: every cycle, away from the active edge
    always @(negedge clk_in) begin
        if (prev_valid) check("pulse_width", {31'b0, instr_valid_out}, 32'd0);
        if (instr_valid_out) begin
            check("instr_out", instr_out, exp_word);
            pulses++;
            last_word = instr_out;
        end
        if (mem_req_out) begin
            check("mem_a_out", mem_a_out, exp_base + grants);
            req_cycles++;
        end
        gnt_seen = mem_req_out && mem_gnt_in;
        gnt_addr = mem_a_out;
        if (gnt_seen) grants++;
        prev_valid = instr_valid_out;
    end

    // arbiter/RAM: byte for a grant appears the next cycle and holds until the next grant
    initial begin
        mem_din_in = 8'h00;
        mem_gnt_in = 1'b1;
        forever begin
            @(posedge clk_in);
            #2;
            if (gnt_seen) mem_din_in = ram[gnt_addr[11:0]];
            mem_gnt_in = (gnt_block == 0);
            if (gnt_block > 0) gnt_block--;
        end
    end

    // one fetch from request to valid pulse; with stall, grants are withheld 3 cycles
    // and rdy_in dropped 2 cycles mid-refill
    task automatic fetch(input logic [31:0] pc, input bit stall);
        bit          exp_hit, seen;
        int          lat, exp_lat, r0;
        logic [7:0]  idx;
        idx      = pc[9:2];
        exp_hit  = m_valid[idx] && (m_tag[idx] == pc[31:10]);
        exp_lat  = exp_hit ? 1 : (stall ? 11 : 6);
        exp_base = {pc[31:2], 2'b00};
        exp_word = ram_word(exp_base);
        grants   = 0;
        r0       = req_cycles;
        if_pc_in  = pc;
        if_req_in = 1'b1;
        lat  = 0;
        seen = 0;
        while (!seen && lat < 100) begin
            @(negedge clk_in);
            if (instr_valid_out) begin
                seen = 1;
                check("req_low_at_pulse", {31'b0, mem_req_out}, 32'd0);
            end else begin
                lat++;
                cyc();
                if (stall && lat == 2) gnt_block = 3;
                if (stall && lat == 6) rdy_in = 1'b0;
                if (stall && lat == 8) rdy_in = 1'b1;
            end
        end
        #1;
        check("valid_seen", {31'b0, seen}, 32'd1);
        check("latency", lat, exp_lat);
        check("grants", grants, exp_hit ? 0 : 4);
        if (exp_hit) check("hit_no_req", req_cycles - r0, 32'd0);
        cyc();
        if_req_in = 1'b0;
        if (!exp_hit) begin
            m_valid[idx] = 1;
            m_tag[idx]   = pc[31:10];
        end
    endtask

    initial begin
        int p0;
        for (int i = 0; i < 4096; i++) ram[i] = 8'((i * 37 + 11) & 8'hff);
        ram[0] = 8'h13; ram[1] = 8'h05; ram[2] = 8'h10; ram[3] = 8'h00;
        clear_model();
        rst_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0; if_req_in = 1'b0; if_pc_in = 32'h0;
        #1;
        check("rst_valid", {31'b0, instr_valid_out}, 32'd0);
        check("rst_instr", instr_out, 32'd0);
        check("rst_req", {31'b0, mem_req_out}, 32'd0);
        check("rst_addr", mem_a_out, 32'd0);
        repeat (2) cyc();
        rst_in = 1'b1;
        cyc();

        // cold miss then hit on pc 0
        fetch(32'h0, 0);
        check("word_pc0", last_word, 32'h00100513);
        fetch(32'h0, 0);
        check("hit_pc0", last_word, 32'h00100513);

        // conflicting tag on index 0 evicts pc 0
        fetch(32'h400, 0);
        check("word_pc400", last_word, 32'h7A55300B);
        fetch(32'h0, 0);
        fetch(32'h24, 0);
        fetch(32'h24, 0);

        // asynchronous reset in the middle of a refill
        exp_base = 32'h38; exp_word = ram_word(32'h38); grants = 0;
        if_pc_in = 32'h38; if_req_in = 1'b1;
        repeat (3) cyc();
        check("pre_rst_req", {31'b0, mem_req_out}, 32'd1);
        #1;
        rst_in = 1'b0;
        #1;
        check("mid_rst_valid", {31'b0, instr_valid_out}, 32'd0);
        check("mid_rst_req", {31'b0, mem_req_out}, 32'd0);
        check("mid_rst_addr", mem_a_out, 32'd0);
        if_req_in = 1'b0;
        cyc();
        rst_in = 1'b1;
        clear_model();
        cyc();
        fetch(32'h24, 0);

        // flush after two bytes received, then refetch pc 0 from scratch
        exp_base = 32'h0; exp_word = ram_word(32'h0); grants = 0; p0 = pulses;
        if_pc_in = 32'h0; if_req_in = 1'b1;
        repeat (4) cyc();
        check("pre_flush_req", {31'b0, mem_req_out}, 32'd1);
        flush_in = 1'b1; if_req_in = 1'b0;
        cyc();
        flush_in = 1'b0;
        @(negedge clk_in);
        #1;
        check("flush_req_low", {31'b0, mem_req_out}, 32'd0);
        check("flush_no_pulse", pulses, p0);
        cyc();
        fetch(32'h0, 0);
        check("refetch_pc0", last_word, 32'h00100513);

        // withheld grants and a global stall mid-refill
        fetch(32'h234, 1);
        fetch(32'h234, 0);
        check("stall_word", last_word, ram_word(32'h234));

        repeat (3) cyc();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
